// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner: per-bit synchronizer, debounce filter with a shared
// threshold, and sticky rise/fall pending flags merged into one interrupt.
module gpio_in_conditioner #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_pad_gpio,
  input  logic [CNT_W-1:0] i_db_limit,
  input  logic [WIDTH-1:0] i_rise_en,
  input  logic [WIDTH-1:0] i_fall_en,
  input  logic [WIDTH-1:0] i_clr,
  output logic [WIDTH-1:0] o_gpio,
  output logic [WIDTH-1:0] o_rise_pend,
  output logic [WIDTH-1:0] o_fall_pend,
  output logic             o_irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  synced;
  logic [WIDTH-1:0]                  stable_q, stable_d;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]                  accept;
  logic [WIDTH-1:0]                  rise_pend_q, rise_pend_d;
  logic [WIDTH-1:0]                  fall_pend_q, fall_pend_d;

  assign synced = sync_q[SYNC_STAGES-1];

  // State register: synchronizer chain, debounce state and pending flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      stable_q    <= '0;
      cnt_q       <= '0;
      rise_pend_q <= '0;
      fall_pend_q <= '0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], i_pad_gpio};
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      rise_pend_q <= rise_pend_d;
      fall_pend_q <= fall_pend_d;
    end
  end

  // Debounce: count while the synced level disagrees, accept once the count reaches the limit
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    accept   = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (synced[k] == stable_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] >= i_db_limit) begin
        accept[k]   = 1'b1;
        stable_d[k] = synced[k];
        cnt_d[k]    = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  // A set landing together with a clear wins, so no edge is ever lost
  always_comb begin
    rise_pend_d = (rise_pend_q & ~i_clr) | (accept &  synced & i_rise_en);
    fall_pend_d = (fall_pend_q & ~i_clr) | (accept & ~synced & i_fall_en);
  end

  assign o_gpio      = stable_q;
  assign o_rise_pend = rise_pend_q;
  assign o_fall_pend = fall_pend_q;
  assign o_irq       = (|rise_pend_q) | (|fall_pend_q);

endmodule
